// File: rtl/video_pkg.sv
// Shared types and defaults for the video pixel fetch path.
// RGB565 pixel type, fetch FSM states, default panel geometry.
package video_pkg;

   localparam int HACTIVE_DEF = 240;
   localparam int VACTIVE_DEF = 320;

   typedef logic [15:0] rgb565_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DRAIN,
      ST_DONE
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock prefetch FIFO with show-ahead read data.
// Flush empties the FIFO and overrides push/pop in the same cycle.
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   localparam int AW    = $clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage write; contents need no reset.
   always_ff @(posedge clk) begin
      if (do_push && !rst && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/video_pixel_fetch.sv
// Framebuffer prefetch: reads words into a FIFO and streams them
// out one per dot tick, aligned with the incoming sync signals.
module video_pixel_fetch
   import video_pkg::*;
#(
   parameter int HACTIVE               = HACTIVE_DEF,
   parameter int VACTIVE               = VACTIVE_DEF,
   parameter int DATA_W                = 16,
   parameter int ADDR_W                = 17,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int FIFO_DEPTH            = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              dotclk,
   input  logic              hsync,
   input  logic              vsync,
   input  logic              active,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] pix_rgb,
   output logic              pix_de,
   output logic              pix_hsync,
   output logic              pix_vsync,
   output logic              underflow
);

   localparam int TOTAL = HACTIVE * VACTIVE;
   localparam int CNT_W = $clog2(TOTAL + 1);
   localparam int CW    = $clog2(FIFO_DEPTH) + 1;

   if (longint'(HACTIVE) * longint'(VACTIVE) > (longint'(1) << ADDR_W))
   begin : g_frame_too_big
      $error("frame does not fit in the address space");
   end

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
   begin : g_depth_not_pow2
      $error("FIFO_DEPTH must be a power of two");
   end

   fetch_state_t      state;
   fetch_state_t      state_n;
   logic [ADDR_W-1:0] addr_n;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_n;
   logic              vsync_q;
   logic              dotclk_q;
   logic              frame_start;
   logic              dot_tick;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] fifo_rdata;
   logic              full;
   logic              empty;
   logic [CW-1:0]     fcount;

   assign frame_start = vsync_q & ~vsync;
   assign dot_tick    = ~dotclk_q & dotclk;
   assign pop         = dot_tick & active & ~empty;

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (frame_start),
      .push  (push),
      .wdata (mem_rdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (fcount)
   );

   // Edge detectors for frame start and dot tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q  <= 1'b1;
         dotclk_q <= 1'b1;
      end else begin
         vsync_q  <= vsync;
         dotclk_q <= dotclk;
      end
   end

   // Fetch state, address and word count registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mem_addr <= BASE_ADDR;
         cnt      <= '0;
      end else begin
         state    <= state_n;
         mem_addr <= addr_n;
         cnt      <= cnt_n;
      end
   end

   // Next-state, request and push decisions.
   always_comb begin
      state_n = state;
      addr_n  = mem_addr;
      cnt_n   = cnt;
      mem_req = 1'b0;
      push    = 1'b0;
      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (frame_start) begin
               state_n = ST_REQ;
               addr_n  = BASE_ADDR;
               cnt_n   = '0;
            end
         end
         ST_REQ: begin
            mem_req = (fcount < CW'(FIFO_DEPTH));
            if (frame_start) begin
               if (mem_req && !mem_ack) begin
                  state_n = ST_DRAIN;
               end else begin
                  addr_n = BASE_ADDR;
                  cnt_n  = '0;
               end
            end else if (mem_req && mem_ack) begin
               push   = ~full;
               addr_n = mem_addr + ADDR_W'(1);
               cnt_n  = cnt + CNT_W'(1);
               if (cnt_n == CNT_W'(TOTAL)) state_n = ST_DONE;
            end
         end
         ST_DRAIN: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               state_n = ST_REQ;
               addr_n  = BASE_ADDR;
               cnt_n   = '0;
            end
         end
      endcase
   end

   // Registered pixel output stage and sticky underflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_rgb   <= '0;
         pix_de    <= 1'b0;
         pix_hsync <= 1'b1;
         pix_vsync <= 1'b1;
         underflow <= 1'b0;
      end else begin
         if (dot_tick) begin
            pix_de    <= active;
            pix_hsync <= hsync;
            pix_vsync <= vsync;
            pix_rgb   <= (active && !empty) ? fifo_rdata : '0;
         end
         if (frame_start)
            underflow <= 1'b0;
         else if (dot_tick && active && empty)
            underflow <= 1'b1;
      end
   end

endmodule
